lbp_img_host: RTL

Memory-side responder for the LBP engine's gray/lbp interface. Accepts a 128x128 8-bit gray image as a raster-order byte stream, then serves combinational pixel reads on the gray port, captures result writes on the lbp port, and, once the engine signals finish, streams the LBP result image back out. It sits between the system loader/unloader and the LBP engine, owning both image buffers.

---
 rtl/lbp_img_host.sv | 98 +++++++++
 1 files changed

// File: rtl/lbp_img_host.sv
// lbp_img_host: gray/lbp image buffer host for the LBP engine; define LBP_IMG_HOST_BORDER_ZERO_EN to dump border pixels as 0
module lbp_img_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W:0]   lbp_wr_cnt,
  output logic              done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int HALF = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {LOAD, SERVE, DUMP, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d, dump_addr_q, dump_addr_d;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] gray_mem [DEPTH];
  logic [DATA_W-1:0] lbp_mem [DEPTH];
  logic gray_we, lbp_we;
  logic [DATA_W-1:0] lbp_rd;
  assign gray_we = state_q == LOAD && load_valid;
  assign lbp_we = state_q == SERVE && lbp_valid;
  assign load_ready = state_q == LOAD;
  assign gray_ready = state_q == SERVE;
  assign dump_valid = state_q == DUMP;
  assign done = state_q == DONE;
  assign dump_addr = dump_addr_q;
  assign lbp_wr_cnt = wr_cnt_q;
  assign gray_data = (gray_ready && gray_req) ? gray_mem[gray_addr] : '0;
  assign lbp_rd = lbp_mem[dump_addr_q];
`ifdef LBP_IMG_HOST_BORDER_ZERO_EN
  logic [ADDR_W-HALF-1:0] row;
  logic [HALF-1:0] col;
  assign row = dump_addr_q[ADDR_W-1:HALF];
  assign col = dump_addr_q[HALF-1:0];
  assign dump_data = (row == '0 || row == '1 || col == '0 || col == '1) ? '0 : lbp_rd;
`else
  assign dump_data = lbp_rd;
`endif
  // state and counters; the memories are intentionally kept out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ld_cnt_q <= '0;
      dump_addr_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ld_cnt_q <= ld_cnt_d;
      dump_addr_q <= dump_addr_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  // image buffers: gray filled by the loader, lbp filled by the engine
  always_ff @(posedge clk) begin
    if (gray_we) gray_mem[ld_cnt_q] <= load_data;
    if (lbp_we) lbp_mem[lbp_addr] <= lbp_data;
  end
  // phase sequencing and counter advance; the last address of a phase ends it
  always_comb begin
    state_d = state_q;
    ld_cnt_d = ld_cnt_q;
    dump_addr_d = dump_addr_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      LOAD: if (load_valid) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        state_d = ld_cnt_q == LAST ? SERVE : LOAD;
      end
      SERVE: begin
        wr_cnt_d = (lbp_valid && wr_cnt_q != CNT_MAX) ? wr_cnt_q + 1'b1 : wr_cnt_q;
        state_d = finish ? DUMP : SERVE;
      end
      DUMP: if (dump_ready) begin
        dump_addr_d = dump_addr_q + 1'b1;
        state_d = dump_addr_q == LAST ? DONE : DUMP;
      end
      default: ;
    endcase
  end
endmodule
